// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start bit, 5..9 data bits LSB first, optional parity, 1 or 2 stop bits.
// Each bit lasts OVERSAMPLE b_tick strobes; tx, tx_busy and tx_done are registered.
module uart_tx_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 b_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 two_stop,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 tx
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_PARITY = 3'd4,
    S_STOP   = 3'd5
  } state_t;

  localparam logic [5:0] TICK_LAST = 6'(OVERSAMPLE - 1);
  localparam logic [3:0] BIT_LAST  = 4'(DATA_BITS - 1);

  state_t               state_q, state_d;
  logic [5:0]           tick_q, tick_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 par_en_q, par_en_d;
  logic                 par_odd_q, par_odd_d;
  logic                 two_stop_q, two_stop_d;
  logic                 stop_q, stop_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 in_bit;
  logic                 bit_end;

  assign in_bit  = (state_q == S_START) || (state_q == S_DATA) ||
                   (state_q == S_PARITY) || (state_q == S_STOP);
  assign bit_end = in_bit && b_tick && (tick_q == TICK_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tick_q     <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      two_stop_q <= 1'b0;
      stop_q     <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      data_q     <= data_d;
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      two_stop_q <= two_stop_d;
      stop_q     <= stop_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    data_d     = data_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    two_stop_d = two_stop_q;
    stop_d     = stop_q;
    if (in_bit && b_tick) tick_d = bit_end ? 6'd0 : tick_q + 6'd1;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_WAIT;
          shreg_d    = tx_data;
          data_d     = tx_data;
          par_en_d   = parity_en;
          par_odd_d  = parity_odd;
          two_stop_d = two_stop;
          tick_d     = '0;
          bit_d      = '0;
          stop_d     = 1'b0;
        end
      end
      // A tick coincident with acceptance was seen in IDLE, so WAIT aligns to the next one.
      S_WAIT: begin
        tick_d = '0;
        if (b_tick) state_d = S_START;
      end
      S_START: begin
        bit_d = '0;
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (bit_q == BIT_LAST) state_d = par_en_q ? S_PARITY : S_STOP;
          else                   bit_d   = bit_q + 4'd1;
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          stop_d  = 1'b0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (two_stop_q && !stop_q) begin
            stop_d = 1'b1;
          end else begin
            state_d = S_IDLE;
            stop_d  = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered tx lines up with the state edge.
  always_comb begin
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
      S_PARITY: tx_d = (^data_q) ^ par_odd_q;
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_STOP) && (state_d == S_IDLE);
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: an 8-bit/16x instance and a 7-bit/4x instance on a shared
// b_tick, checked clock by clock against frames built from the character format rules.
module tb_uart_tx_cfg;
  localparam int TDIV = 4;
  localparam int OS_A = 16;
  localparam int OS_B = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       b_tick = 1'b0;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic [7:0] data_a = '0;
  logic [6:0] data_b = '0;
  logic       parity_en = 1'b0;
  logic       parity_odd = 1'b0;
  logic       two_stop = 1'b0;
  logic       busy_a, done_a, tx_a;
  logic       busy_b, done_b, tx_b;

  logic       sel = 1'b0;
  logic       cur_tx, cur_busy, cur_done;
  assign cur_tx   = sel ? tx_b   : tx_a;
  assign cur_busy = sel ? busy_b : busy_a;
  assign cur_done = sel ? done_b : done_a;

  int n_cmp = 0;
  int n_bad = 0;
  int tick_cnt = 0;
  bit scramble = 1'b0;
  bit exp_q[$];

  uart_tx_cfg #(.DATA_BITS(8), .OVERSAMPLE(OS_A)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .b_tick(b_tick), .tx_data(data_a),
    .parity_en(parity_en), .parity_odd(parity_odd), .two_stop(two_stop),
    .tx_busy(busy_a), .tx_done(done_a), .tx(tx_a)
  );

  uart_tx_cfg #(.DATA_BITS(7), .OVERSAMPLE(OS_B)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .b_tick(b_tick), .tx_data(data_b),
    .parity_en(parity_en), .parity_odd(parity_odd), .two_stop(two_stop),
    .tx_busy(busy_b), .tx_done(done_b), .tx(tx_b)
  );

  initial forever #5 clk = ~clk;

  // b_tick changes on the falling edge; sampled after a rising edge it shows what that edge saw.
  initial forever begin
    @(negedge clk);
    tick_cnt = (tick_cnt + 1) % TDIV;
    b_tick   = (tick_cnt == 0);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input bit v);
    if (sel) start_b = v;
    else     start_a = v;
  endtask

  task automatic set_inputs(input logic [8:0] d, input bit pen, input bit podd, input bit two);
    if (sel) data_b = d[6:0];
    else     data_a = d[7:0];
    parity_en  = pen;
    parity_odd = podd;
    two_stop   = two;
  endtask

  task automatic do_scramble();
    data_a     = 8'($urandom);
    data_b     = 7'($urandom);
    parity_en  = 1'($urandom);
    parity_odd = 1'($urandom);
    two_stop   = 1'($urandom);
  endtask

  // Reference frame: start, data LSB first, optional parity making the ones count even/odd, stop(s).
  function automatic void build(input logic [8:0] d, input int nb, input bit pen,
                                input bit podd, input bit two);
    int ones;
    ones = 0;
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      exp_q.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pen) exp_q.push_back(((ones % 2) == 1) ^ podd);
    exp_q.push_back(1'b1);
    if (two) exp_q.push_back(1'b1);
  endfunction

  // Called right after the accepting edge; returns right after the tx_done edge.
  task automatic check_frame(input string nm);
    int os, n, ticks, waited, j, guard, ctl_bad;
    int bad[$];
    os = sel ? OS_B : OS_A;
    n  = exp_q.size();
    n_cmp++;
    if (cur_busy !== 1'b1 || cur_tx !== 1'b1 || cur_done !== 1'b0) begin
      n_bad++;
      $display("FAIL %s accept: busy=%b tx=%b done=%b, want 1 1 0", nm, cur_busy, cur_tx, cur_done);
    end
    ticks = 0;
    waited = 0;
    while (cur_tx !== 1'b0 && waited < 8 * TDIV) begin
      if (scramble) do_scramble();
      cyc();
      waited++;
      if (b_tick) ticks++;
    end
    n_cmp++;
    if (cur_tx !== 1'b0 || ticks != 1) begin
      n_bad++;
      $display("FAIL %s start latency: tx=%b after %0d ticks, want 0 after 1 tick", nm, cur_tx, ticks);
    end
    for (int k = 0; k < n; k++) bad.push_back(0);
    j = 0;
    guard = 0;
    ctl_bad = 0;
    while (j < n * os && guard < n * os * TDIV + 16) begin
      if (cur_tx !== exp_q[j / os]) bad[j / os]++;
      if (cur_busy !== 1'b1 || cur_done !== 1'b0) ctl_bad++;
      if (scramble) do_scramble();
      cyc();
      guard++;
      if (b_tick) j++;
    end
    for (int k = 0; k < n; k++) begin
      n_cmp++;
      if (bad[k] != 0) begin
        n_bad++;
        $display("FAIL %s bit %0d: %0d clocks wrong, want tx=%b throughout", nm, k, bad[k], exp_q[k]);
      end
    end
    n_cmp++;
    if (ctl_bad != 0) begin
      n_bad++;
      $display("FAIL %s busy/done in frame: %0d bad clocks, want busy=1 done=0", nm, ctl_bad);
    end
    n_cmp++;
    if (j != n * os || cur_done !== 1'b1 || cur_busy !== 1'b0 || cur_tx !== 1'b1) begin
      n_bad++;
      $display("FAIL %s frame end: ticks=%0d done=%b busy=%b tx=%b, want ticks=%0d done=1 busy=0 tx=1",
               nm, j, cur_done, cur_busy, cur_tx, n * os);
    end
  endtask

  task automatic send(input logic [8:0] d, input bit pen, input bit podd, input bit two,
                      input bit coinc, input string nm);
    int guard;
    build(d, sel ? 7 : 8, pen, podd, two);
    set_inputs(d, pen, podd, two);
    guard = 0;
    while (coinc && tick_cnt != TDIV - 1 && guard < 2 * TDIV) begin
      cyc();
      guard++;
    end
    set_start(1'b1);
    cyc();
    set_start(1'b0);
    if (coinc) begin
      n_cmp++;
      if (b_tick !== 1'b1) begin
        n_bad++;
        $display("FAIL %s coincident tick: b_tick=%b at accept, want 1", nm, b_tick);
      end
    end
    check_frame(nm);
    cyc();
    n_cmp++;
    if (cur_done !== 1'b0 || cur_busy !== 1'b0 || cur_tx !== 1'b1) begin
      n_bad++;
      $display("FAIL %s after done: done=%b busy=%b tx=%b, want 0 0 1", nm, cur_done, cur_busy, cur_tx);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    n_cmp++;
    if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_a: tx=%b busy=%b done=%b, want 1 0 0", tx_a, busy_a, done_a);
    end
    n_cmp++;
    if (tx_b !== 1'b1 || busy_b !== 1'b0 || done_b !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_b: tx=%b busy=%b done=%b, want 1 0 0", tx_b, busy_b, done_b);
    end
    cyc();
  endtask

  task automatic test_formats();
    sel = 1'b0;
    send(9'h0A5, 1'b0, 1'b0, 1'b0, 1'b0, "8N1_A5");
    send(9'h003, 1'b1, 1'b0, 1'b0, 1'b0, "8E1_03");
    send(9'h003, 1'b1, 1'b1, 1'b1, 1'b0, "8O2_03");
  endtask

  task automatic test_seven_bit();
    sel = 1'b1;
    send(9'h041, 1'b0, 1'b0, 1'b0, 1'b0, "7N1_41");
    for (int i = 0; i < 4; i++)
      send(9'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, "7bit_rand");
    sel = 1'b0;
  endtask

  task automatic test_random();
    sel = 1'b0;
    for (int i = 0; i < 5; i++)
      send(9'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), "8bit_rand");
  endtask

  task automatic test_coincident();
    sel = 1'b0;
    send(9'h05A, 1'b1, 1'b0, 1'b0, 1'b1, "coincident");
  endtask

  task automatic test_back_to_back();
    logic [8:0] d2;
    bit pen2, podd2, two2;
    sel = 1'b0;
    build(9'h0C6, 8, 1'b1, 1'b1, 1'b0);
    set_inputs(9'h0C6, 1'b1, 1'b1, 1'b0);
    start_a = 1'b1;
    cyc();
    scramble = 1'b1;
    check_frame("busy_cfg");
    scramble = 1'b0;
    d2    = 9'($urandom);
    pen2  = 1'($urandom);
    podd2 = 1'($urandom);
    two2  = 1'($urandom);
    build(d2, 8, pen2, podd2, two2);
    set_inputs(d2, pen2, podd2, two2);
    cyc();
    check_frame("b2b");
    start_a = 1'b0;
    cyc();
    n_cmp++;
    if (done_a !== 1'b0 || busy_a !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b idle: done=%b busy=%b, want 0 0", done_a, busy_a);
    end
  endtask

  task automatic test_reset_mid();
    int j, guard, quiet_bad;
    logic [8:0] d;
    sel = 1'b0;
    d = 9'($urandom) & 9'h0F7;
    set_inputs(d, 1'b1, 1'b0, 1'b1);
    start_a = 1'b1;
    cyc();
    start_a = 1'b0;
    guard = 0;
    while (tx_a !== 1'b0 && guard < 8 * TDIV) begin
      cyc();
      guard++;
    end
    j = 0;
    while (j < 4 * OS_A + 3 && guard < 4000) begin
      cyc();
      guard++;
      if (b_tick) j++;
    end
    n_cmp++;
    if (tx_a !== 1'b0 || busy_a !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid pre: tx=%b busy=%b in data bit 3, want 0 1", tx_a, busy_a);
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_cmp++;
    if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid: tx=%b busy=%b done=%b, want 1 0 0", tx_a, busy_a, done_a);
    end
    quiet_bad = 0;
    repeat (3 * OS_A * TDIV) begin
      cyc();
      if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) quiet_bad++;
    end
    n_cmp++;
    if (quiet_bad != 0) begin
      n_bad++;
      $display("FAIL rst_mid quiet: %0d clocks active, want 0", quiet_bad);
    end
    send(9'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, "after_rst");
  endtask

  initial begin
    test_reset();
    test_formats();
    test_seven_bit();
    test_random();
    test_coincident();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
